// File: rtl/fetch_unit.sv
// fetch_unit
//
// Instruction fetch stage sitting directly in front of the main decoder.
// Owns the program counter, issues in-order word requests to instruction
// memory, buffers the returned words together with their PCs in a small
// FIFO and hands them to decode under a valid/ready handshake. A redirect
// from execute (taken branch / jal) flushes the FIFO and arranges for every
// response still owed by memory to be discarded when it arrives.
//
// Parameters:
//   RESET_PC  first fetch address after reset
//   DEPTH     FIFO entries and maximum in-flight credit (power of 2, >= 2)
//
// Optional feature (compile-time macro FETCH_MISALIGN_TRAP_EN):
//   Adds the `misaligned` output and a RUN/HALT state machine. A redirect to
//   a target with non-zero low bits halts fetch until a redirect to an
//   aligned target arrives. Without the macro the low two target bits are
//   simply forced to zero.
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   synchronous, active-high
//   imem_req_valid   out  fetch request valid
//   imem_req_ready   in   memory accepts request
//   imem_req_addr    out  word address of request, bits [1:0] always 00
//   imem_rsp_valid   in   response word valid, one per accepted request, in order
//   imem_rsp_data    in   response instruction word
//   redirect         in   taken branch/jump this cycle
//   redirect_target  in   new PC
//   instr_valid      out  instruction available to decode
//   instr_ready      in   decode consumes the instruction
//   instr            out  instruction at FIFO head
//   instr_pc         out  PC of instr
//   opcode           out  instr[6:0], feeds the main decoder
//   misaligned       out  (FETCH_MISALIGN_TRAP_EN only) fetch halted on a
//                         misaligned redirect target

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] pending;
    logic [CW-1:0] drop;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];

    logic [CW:0]   credit_used;
    logic          run_ok;
    logic          req_fire;
    logic          fifo_push;
    logic          fifo_pop;
    logic [31:0]   target_aligned;

    assign target_aligned = {redirect_target[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0] state;
    logic       target_misaligned;

    assign target_misaligned = |redirect_target[1:0];
    assign run_ok            = (state == ST_RUN);

    // Trap state machine: every redirect re-decides between RUN and HALT
    // based on the alignment of its target; the flush itself is handled by
    // the main datapath exactly as for an aligned redirect.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_RUN;
            misaligned <= 1'b0;
        end else if (redirect) begin
            if (target_misaligned) begin
                state      <= ST_HALT;
                misaligned <= 1'b1;
            end else begin
                state      <= ST_RUN;
                misaligned <= 1'b0;
            end
        end
    end
`else
    logic unused_target_lsbs;

    assign unused_target_lsbs = ^redirect_target[1:0];
    assign run_ok             = 1'b1;
`endif

    // Words already buffered plus words still owed by memory may never
    // exceed the FIFO size, so every response always has a slot waiting.
    assign credit_used    = {1'b0, fifo_count} + {1'b0, pending};
    assign imem_req_valid = !reset && !redirect && run_ok && (credit_used < DEPTH_LIM);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses belonging to a flushed stream are swallowed while drop is
    // non-zero; a response landing in the redirect cycle itself is stale too.
    assign fifo_push = imem_rsp_valid && !redirect && (drop == '0);
    assign fifo_pop  = instr_valid && instr_ready;

    assign instr_valid = (fifo_count != '0);
    assign instr       = fifo_data[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];
    assign opcode      = instr[6:0];

    // Control state. The pending update is the same in redirect and normal
    // cycles (no request can fire during a redirect); drop is reloaded from
    // pending so that any words owed for earlier redirects are included.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            resp_pc    <= RESET_PC;
            fifo_count <= '0;
            pending    <= '0;
            drop       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            pending <= pending + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect) begin
                drop       <= pending - CW'(imem_rsp_valid);
                fetch_pc   <= target_aligned;
                resp_pc    <= target_aligned;
                fifo_count <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (imem_rsp_valid && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
                if (fifo_push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + AW'(1);
                end
                if (fifo_pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
            end
        end
    end

    // FIFO storage needs no reset; entries are only visible once counted.
    always_ff @(posedge clock) begin
        if (fifo_push) begin
            fifo_data[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]   <= resp_pc;
        end
    end

endmodule
